onchip_ram_arbiter: RTL and testbench
=====================================

// Module: onchip_ram_arbiter
// PURPOSE
//  Shares the single-port 32-bit on-chip RAM (5120 words, 1-cycle read latency) between two
//  Avalon-MM masters (m0 = CPU data, m1 = DMA). Sits between the masters and the RAM slave port.
//  Round-robin arbitration, one access per cycle, tagged read-return pipeline, out-of-range guard.
//  Optional zero-fill of the whole RAM after reset before any master is granted.
// PARAMETERS
//  ADDR_W          13     word address width, masters and RAM
//  DEPTH           5120   implemented words; addresses >= DEPTH are out of range
//  RD_LATENCY      1      cycles from accepted read to ram_readdata valid (1..3)
//  CLEAR_ON_RESET  1      1: zero-fill RAM after reset; 0: grant immediately
// PORTS
//  clk              in   1       single clock for all logic
//  reset_n          in   1       asynchronous active-low reset
//  mN_address       in   ADDR_W  word address, N = 0,1
//  mN_read          in   1       read request
//  mN_write         in   1       write request
//  mN_byteenable    in   4       write byte lanes
//  mN_writedata     in   32      write data
//  mN_waitrequest   out  1       1 = request not accepted this cycle
//  mN_readdata      out  32      read data, valid when mN_readdatavalid
//  mN_readdatavalid out  1       one pulse per accepted read
//  ram_address      out  ADDR_W  to RAM
//  ram_chipselect   out  1       to RAM
//  ram_write        out  1       to RAM
//  ram_byteenable   out  4       to RAM
//  ram_writedata    out  32      to RAM
//  ram_clken        out  1       tied 1
//  ram_readdata     in   32      from RAM
//  init_done        out  1       1 once zero-fill finished (or immediately if CLEAR_ON_RESET=0)
//  oob_err          out  1       sticky: an out-of-range access was accepted
// BEHAVIOUR
//  Reset values: mN_waitrequest=1, mN_readdatavalid=0, ram_chipselect=0, init_done=0,
//   oob_err=0, clear counter=0, rr_last=m1 (so m0 wins first tie).
//  FSM: CLEAR -> ARB. Leaves reset in CLEAR if CLEAR_ON_RESET else ARB.
//   CLEAR: each cycle ram_chipselect=1, ram_write=1, byteenable=4'hF, writedata=0, address=cnt;
//    cnt++; after cnt==DEPTH-1 written -> ARB, init_done=1 next cycle. Both waitrequest=1.
//   ARB: terminal until reset. Request = read|write. One master requesting -> granted.
//    Both -> grant master != rr_last. rr_last updates only on a grant.
//  Grant is combinational: winner's waitrequest=0 same cycle, loser's=1; RAM outputs mux winner.
//  read & write together from one master is illegal: write executes, read ignored (assertion).
//  Out of range (address >= DEPTH): accepted (waitrequest=0), ram_chipselect=0, oob_err set;
//   read still returns one readdatavalid with readdata=32'h0.
//  Read return: tag {master, oob} enters RD_LATENCY-deep shift register on accept; at output,
//   tagged master gets readdatavalid=1, readdata=ram_readdata (0 if oob). Back-to-back reads
//   from alternating masters return in issue order, one per cycle, no bubbles.
//  Non-tagged master's readdata driven 0. Writes produce no response.
//  Reset mid-operation: FSM, counter, tag pipe flushed; in-flight reads are dropped (no valid).
//  Reset mid-CLEAR restarts fill from address 0.
// STRUCTURE
//  Package onchip_ram_arb_pkg: state enum {ST_CLEAR, ST_ARB}, master id constants M0/M1,
//   tag struct {id, oob}.
//  Sub-module rd_return_pipe: parameterised RD_LATENCY tag shift register with flush on reset.
//  Top: FSM + clear counter, round-robin grant, RAM mux, oob compare, response demux.
// TESTING
//  Reset, CLEAR_ON_RESET=1 -> 5120 consecutive zero writes addr 0..5119, init_done at cycle 5121.
//  m0 write 0x10 <- 0xDEADBEEF be=F, then m0 read 0x10 -> readdatavalid 1 cycle later, 0xDEADBEEF.
//  m0,m1 read every cycle for 8 cycles -> grants alternate m0,m1,...; each gets 4 ordered returns.
//  m1 write 0x20 be=4'b0011 data 0x12345678 over 0xAAAAAAAA -> read gives 0xAAAA5678.
//  m0 read addr 5200 -> waitrequest 0, readdatavalid with 0x0, ram_chipselect 0, oob_err=1.
//  reset_n low with read in flight and during CLEAR -> no readdatavalid; fill restarts at 0.

Source files
------------

// File: rtl/onchip_ram_arb_pkg.sv
// Shared types for the on-chip RAM arbiter.
// FSM states, master ids and the read-return tag.
package onchip_ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic id;
    logic oob;
  } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return tag pipe, RD_LATENCY deep.
// Tracks which master owns each RAM read result.
module rd_return_pipe
  import onchip_ram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  rd_tag_t tag_in,
  output logic    vld_out,
  output rd_tag_t tag_out
);

  logic [RD_LATENCY-1:0]    vld_q, vld_d;
  rd_tag_t [RD_LATENCY-1:0] tag_q, tag_d;

  // shift one stage per cycle, new tag enters stage 0
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = push;
    tag_d[0] = tag_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // tag registers; reset drops reads in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign vld_out = vld_q[RD_LATENCY-1];
  assign tag_out = tag_q[RD_LATENCY-1];

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter for the on-chip RAM.
// Zero-fills the RAM after reset, guards out-of-range words.
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int DEPTH          = 5120,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              init_done,
  output logic              oob_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = DEPTH[ADDR_W:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              init_done_q, init_done_d;
  logic              oob_err_q, oob_err_d;

  logic              req0, req1;
  logic              gnt0, gnt1, gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_read, sel_write;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              sel_oob;
  logic              rd_push;
  rd_tag_t           push_tag;
  logic              rd_vld;
  rd_tag_t           rd_tag;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // round-robin grant, idle while clearing or in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && state_q == ST_ARB) begin
      gnt0 = req0 && (!req1 || rr_last_q == M1);
      gnt1 = req1 && (!req0 || rr_last_q == M0);
    end
  end

  assign gnt       = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? m1_address    : m0_address;
  assign sel_read  = gnt1 ? m1_read       : m0_read;
  assign sel_write = gnt1 ? m1_write      : m0_write;
  assign sel_be    = gnt1 ? m1_byteenable : m0_byteenable;
  assign sel_wdata = gnt1 ? m1_writedata  : m0_writedata;
  assign sel_oob   = {1'b0, sel_addr} >= DEPTH_X;

  assign push_tag = '{id: (gnt1 ? M1 : M0), oob: sel_oob};

  // FSM next state, RAM port mux and sticky error
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_last_d      = rr_last_q;
    oob_err_d      = oob_err_q;
    init_done_d    = (state_q == ST_ARB);
    ram_address    = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_byteenable = 4'h0;
    ram_writedata  = '0;
    rd_push        = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_CLEAR: begin
          ram_address    = cnt_q;
          ram_chipselect = 1'b1;
          ram_write      = 1'b1;
          ram_byteenable = 4'hF;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_ARB;
          end
        end
        ST_ARB: begin
          if (gnt) begin
            rr_last_d      = gnt1 ? M1 : M0;
            ram_address    = sel_addr;
            ram_chipselect = !sel_oob;
            ram_write      = sel_write && !sel_oob;
            ram_byteenable = sel_be;
            ram_writedata  = sel_wdata;
            rd_push        = sel_read && !sel_write;
            if (sel_oob) begin
              oob_err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // state, fill counter and arbitration history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      cnt_q       <= '0;
      rr_last_q   <= M1;
      init_done_q <= 1'b0;
      oob_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      init_done_q <= init_done_d;
      oob_err_q   <= oob_err_d;
    end
  end

  rd_return_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (rd_push),
    .tag_in (push_tag),
    .vld_out(rd_vld),
    .tag_out(rd_tag)
  );

  assign m0_waitrequest   = !gnt0;
  assign m1_waitrequest   = !gnt1;
  assign m0_readdatavalid = rd_vld && rd_tag.id == M0;
  assign m1_readdatavalid = rd_vld && rd_tag.id == M1;
  assign m0_readdata      = (m0_readdatavalid && !rd_tag.oob)
                            ? ram_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid && !rd_tag.oob)
                            ? ram_readdata : '0;
  assign ram_clken        = 1'b1;
  assign init_done        = init_done_q;
  assign oob_err          = oob_err_q;

  a_m0_rw: assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_read && m0_write));
  a_m1_rw: assert property (@(posedge clk) disable iff (!reset_n)
    !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter.
// Behavioural 1-cycle RAM plus hand-computed expectations.
module tb_onchip_ram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5120;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic [31:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic [31:0]       ram_readdata = '0;
  logic              init_done, oob_err;

  logic [31:0] mem [8192];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  onchip_ram_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read),
    .m0_write(m0_write), .m0_byteenable(m0_byteenable),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read),
    .m1_write(m1_write), .m1_byteenable(m1_byteenable),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write(ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata),
    .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .init_done(init_done), .oob_err(oob_err)
  );

  // single-port RAM, registered read
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b])
            mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    int n0;
    int n1;
    logic e0;
    logic e1;
    m0_address = '0; m0_read = 0; m0_write = 0;
    m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_read = 0; m1_write = 0;
    m1_byteenable = '0; m1_writedata = '0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_init", init_done, 0);
    chk("rst_oob", oob_err, 0);
    chk("clken", ram_clken, 1);

    // zero-fill sequence
    @(negedge clk);
    reset_n = 1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (!(ram_chipselect === 1'b1 && ram_write === 1'b1 &&
            ram_address === ADDR_W'(i) &&
            ram_byteenable === 4'hF && ram_writedata === 32'h0 &&
            m0_waitrequest === 1'b1 && m1_waitrequest === 1'b1 &&
            init_done === 1'b0))
        bad++;
      @(negedge clk);
    end
    chk("fill_bad_cycles", bad, 0);
    #1;
    chk("init_c5120", init_done, 0);
    chk("idle_cs", ram_chipselect, 0);
    @(negedge clk);
    #1;
    chk("init_c5121", init_done, 1);

    // m0 write then read back
    @(negedge clk);
    m0_address = 13'h10; m0_write = 1;
    m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    chk("m0w_wait", m0_waitrequest, 0);
    chk("m0w_cs", ram_chipselect, 1);
    chk("m0w_we", ram_write, 1);
    chk("m0w_addr", ram_address, 32'h10);
    @(negedge clk);
    m0_write = 0; m0_read = 1;
    #1;
    chk("m0r_wait", m0_waitrequest, 0);
    chk("m0r_we", ram_write, 0);
    @(negedge clk);
    m0_read = 0;
    #1;
    chk("m0r_rdv", m0_readdatavalid, 1);
    chk("m0r_data", m0_readdata, 32'hDEADBEEF);
    chk("m0r_m1rdv", m1_readdatavalid, 0);

    // m1 partial write
    @(negedge clk);
    m1_address = 13'h20; m1_write = 1;
    m1_writedata = 32'hAAAAAAAA; m1_byteenable = 4'hF;
    #1;
    chk("m1w_wait", m1_waitrequest, 0);
    chk("m1w_m0wait", m0_waitrequest, 1);
    @(negedge clk);
    m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
    #1;
    chk("m1w_be", ram_byteenable, 32'h3);
    @(negedge clk);
    m1_write = 0; m1_read = 1;
    #1;
    chk("m1r_wait", m1_waitrequest, 0);
    @(negedge clk);
    m1_read = 0;
    #1;
    chk("m1r_rdv", m1_readdatavalid, 1);
    chk("m1r_data", m1_readdata, 32'hAAAA5678);
    chk("m1r_m0data", m0_readdata, 0);

    // both masters read every cycle; last grant was m1
    @(negedge clk);
    m0_address = 13'h10; m0_read = 1;
    m1_address = 13'h20; m1_read = 1;
    n0 = 0; n1 = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("rr_m0_wait", m0_waitrequest, 32'(j % 2));
      chk("rr_m1_wait", m1_waitrequest, 32'((j + 1) % 2));
      e0 = (j > 0) && ((j - 1) % 2 == 0);
      e1 = (j > 0) && ((j - 1) % 2 == 1);
      chk("rr_m0_rdv", m0_readdatavalid, 32'(e0));
      chk("rr_m1_rdv", m1_readdatavalid, 32'(e1));
      chk("rr_m0_data", m0_readdata, e0 ? 32'hDEADBEEF : 0);
      chk("rr_m1_data", m1_readdata, e1 ? 32'hAAAA5678 : 0);
      n0 += int'(m0_readdatavalid);
      n1 += int'(m1_readdatavalid);
      @(negedge clk);
    end
    m0_read = 0; m1_read = 0;
    #1;
    chk("rr_last_m1_rdv", m1_readdatavalid, 1);
    chk("rr_last_m1_data", m1_readdata, 32'hAAAA5678);
    chk("rr_last_m0_rdv", m0_readdatavalid, 0);
    n0 += int'(m0_readdatavalid);
    n1 += int'(m1_readdatavalid);
    chk("rr_m0_returns", n0, 4);
    chk("rr_m1_returns", n1, 4);

    // out-of-range read; RAM output still holds a stale word
    @(negedge clk);
    m0_address = 13'd5200; m0_read = 1;
    #1;
    chk("oob_wait", m0_waitrequest, 0);
    chk("oob_cs", ram_chipselect, 0);
    chk("oob_err_pre", oob_err, 0);
    @(negedge clk);
    m0_read = 0;
    #1;
    chk("oob_rdv", m0_readdatavalid, 1);
    chk("oob_data", m0_readdata, 0);
    chk("oob_err", oob_err, 1);

    // range boundary: 5119 in range, 5120 out
    @(negedge clk);
    m1_address = 13'd5119; m1_read = 1;
    #1;
    chk("last_cs", ram_chipselect, 1);
    chk("last_addr", ram_address, 32'd5119);
    @(negedge clk);
    m1_address = 13'd5120;
    #1;
    chk("last_rdv", m1_readdatavalid, 1);
    chk("last_data", m1_readdata, 0);
    chk("depth_cs", ram_chipselect, 0);
    chk("depth_wait", m1_waitrequest, 0);
    @(negedge clk);
    m1_read = 0;

    // reset with a read in flight
    @(negedge clk);
    m0_address = 13'h10; m0_read = 1;
    @(posedge clk);
    #1;
    chk("inflight_rdv", m0_readdatavalid, 1);
    reset_n = 0;
    m0_read = 0;
    #1;
    chk("flush_rdv", m0_readdatavalid, 0);
    chk("flush_oob", oob_err, 0);
    chk("flush_cs", ram_chipselect, 0);
    chk("flush_init", init_done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!(ram_chipselect === 1'b1 && ram_write === 1'b1 &&
            ram_address === ADDR_W'(i) &&
            m0_readdatavalid === 1'b0))
        bad++;
      @(negedge clk);
    end
    chk("refill_bad_cycles", bad, 0);

    // reset during fill restarts at word 0
    #2;
    reset_n = 0;
    #1;
    chk("midclr_cs", ram_chipselect, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("restart_cs", ram_chipselect, 1);
    chk("restart_addr0", ram_address, 0);
    @(negedge clk);
    #1;
    chk("restart_addr1", ram_address, 1);
    chk("restart_init", init_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
